fp_add_arbiter: RTL and testbench

- Shares one pipelined floating-point adder (fixed latency, no handshake, one operation per cycle) between NUM_REQ requesters.
- Does round-robin arbitration with valid/ready handshakes and drives the granted operands into the adder.
- Carries a requester tag through a shift pipeline that matches the adder latency, then steers each result back to its originator.
- Sits between the vector/DSP issue logic and the shared adder instance.

---
 rtl/fp_add_arbiter.sv | 125 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin sharing of one fixed-latency pipelined FP adder
//               among NUM_REQ requesters, with tag-based result steering.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]       req_a,
    input  logic [NUM_REQ*WIDTH-1:0]       req_b,
    output logic [WIDTH-1:0]               add_a,
    output logic [WIDTH-1:0]               add_b,
    input  logic [WIDTH-1:0]               add_result,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [WIDTH-1:0]               rsp_result,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight,
    output logic                           idle
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int IF_W  = $clog2(LATENCY+1);
    localparam logic [TAG_W-1:0] c_LAST_IDX = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]   r_ptr;
    logic               w_grant_en;
    logic               w_issue;
    logic [TAG_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_ready;

    logic [LATENCY-1:0] r_stg_vld;
    logic [TAG_W-1:0]   r_stg_tag [LATENCY];
    logic [IF_W-1:0]    w_count;

    // Grants are suppressed during reset so requesters never see a
    // handshake that the pipeline would then discard.
    assign w_grant_en = rst_n && !hold;

    always_comb begin : p_arbitrate
        logic [TAG_W-1:0] w_scan;
        w_issue     = 1'b0;
        w_grant_idx = '0;
        w_ready     = '0;
        w_scan      = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_en && !w_issue && req_valid[w_scan]) begin
                w_issue     = 1'b1;
                w_grant_idx = w_scan;
            end
            w_scan = (w_scan == c_LAST_IDX) ? '0 : w_scan + TAG_W'(1);
        end
        if (w_issue) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready = w_ready;

    always_comb begin : p_operands
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                add_a = req_a[i*WIDTH +: WIDTH];
                add_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap compare keeps non-power-of-two NUM_REQ correct.
    always_ff @(posedge clk or negedge rst_n) begin : p_pointer
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_tag_pipe
        if (!rst_n) begin
            r_stg_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_stg_tag[s] <= '0;
            end
        end else begin
            r_stg_vld[0] <= w_issue;
            r_stg_tag[0] <= w_grant_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_stg_vld[s] <= r_stg_vld[s-1];
                r_stg_tag[s] <= r_stg_tag[s-1];
            end
        end
    end

    always_comb begin : p_response
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = r_stg_vld[LATENCY-1] && (r_stg_tag[LATENCY-1] == TAG_W'(i));
        end
    end

    assign rsp_result = add_result;

    // The last stage is still counted in its response cycle, so an issue and
    // a response in the same cycle leave the count unchanged.
    always_comb begin : p_in_flight
        w_count = '0;
        for (int s = 0; s < LATENCY; s++) begin
            w_count = w_count + IF_W'(r_stg_vld[s]);
        end
    end

    assign in_flight = w_count;
    assign idle      = (w_count == '0) && !(|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// Testbench for fp_add_arbiter: directed vectors, fp16 pipelined adder model,
// queue-based scoreboard checked by an independent response monitor.
module tb_fp_add_arbiter;

    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     hold = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_result;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic [2:0]               in_flight;
    logic                     idle;

    fp_add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .in_flight  (in_flight),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Requester operands and hand-computed sums
    logic [15:0] op_a [NUM_REQ];
    logic [15:0] op_b [NUM_REQ];
    logic [15:0] exp_sum [NUM_REQ];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    // Positive normal/zero fp16 adder, exact for small integer values
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, sum;
        int     p;
        sa = (a[14:10] == 5'd0) ? 64'd0 : (longint'({1'b1, a[9:0]}) << a[14:10]);
        sb = (b[14:10] == 5'd0) ? 64'd0 : (longint'({1'b1, b[9:0]}) << b[14:10]);
        sum = sa + sb;
        if (sum == 0) return 16'h0000;
        p = 0;
        for (int k = 0; k < 48; k++) if (sum[k]) p = k;
        return {1'b0, 5'(p - 10), 10'(sum >> (p - 10))};
    endfunction

    logic [15:0] pipe [LATENCY];
    initial for (int k = 0; k < LATENCY; k++) pipe[k] = '0;
    always @(posedge clk) begin
        pipe[0] <= fp16_add(add_a, add_b);
        for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
    assign add_result = pipe[LATENCY-1];

    // Scoreboard
    typedef struct {
        int          idx;
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   sb_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    exp_t               mon_e;
    logic [NUM_REQ-1:0] mon_oh;
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected rsp_valid", rsp_valid, 0);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                chk("rsp_valid", rsp_valid, mon_oh);
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // One cycle: drive at posedge+1, check at negedge, return at next posedge+1
    task automatic step(input logic [3:0] v, input logic h, input logic [3:0] exp_rdy,
                        input int exp_if, input int exp_idle);
        logic [15:0] ea, eb;
        req_valid = v;
        hold      = h;
        @(negedge clk);
        chk("req_ready", req_ready, exp_rdy);
        ea = '0;
        eb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i]) begin
                ea = op_a[i];
                eb = op_b[i];
                if (sb_en) sb.push_back('{idx: i, res: exp_sum[i], cyc: cyc + LATENCY});
            end
        end
        chk("add_a", add_a, ea);
        chk("add_b", add_b, eb);
        if (exp_if >= 0)   chk("in_flight", in_flight, exp_if);
        if (exp_idle >= 0) chk("idle", idle, exp_idle);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset in_flight", in_flight, 0);
        chk("reset add_a", add_a, 0);
        chk("reset add_b", add_b, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    task automatic drain(input int start_if);
        for (int n = start_if; n >= 0; n--) step(4'b0000, 1'b0, 4'b0000, n, (n == 0) ? 1 : 0);
    endtask

    logic [15:0] s_a   [8] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
                               16'h4400, 16'h4500, 16'h4600, 16'h4700};
    logic [15:0] s_sum [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                               16'h4500, 16'h4600, 16'h4700, 16'h4800};

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; exp_sum[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Single op: 1.0 + 2.0 = 3.0
        op_a[0] = 16'h3C00; op_b[0] = 16'h4000; exp_sum[0] = 16'h4200;
        step(4'b0001, 1'b0, 4'b0001, 0, 0);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 0, 1);

        // Full contention from ptr=0
        do_reset();
        op_a[0] = 16'h3C00; op_a[1] = 16'h4000; op_a[2] = 16'h4200; op_a[3] = 16'h4400;
        for (int i = 0; i < NUM_REQ; i++) op_b[i] = 16'h3C00;
        exp_sum[0] = 16'h4000; exp_sum[1] = 16'h4200; exp_sum[2] = 16'h4400; exp_sum[3] = 16'h4500;
        step(4'b1111, 1'b0, 4'b0001, 0, 0);
        step(4'b1110, 1'b0, 4'b0010, 1, 0);
        step(4'b1100, 1'b0, 4'b0100, 2, 0);
        step(4'b1000, 1'b0, 4'b1000, 3, 0);
        drain(4);

        // Fairness: req0 and req2 alternate
        op_a[0] = 16'h3C00; op_b[0] = 16'h3C00; exp_sum[0] = 16'h4000;
        op_a[2] = 16'h4000; op_b[2] = 16'h4000; exp_sum[2] = 16'h4400;
        for (int k = 0; k < 8; k++)
            step(4'b0101, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b0100, (k < 4) ? k : 4, 0);
        drain(4);

        // Streaming: req1, a = k*1.0, b = 1.0
        op_b[1] = 16'h3C00;
        for (int k = 0; k < 8; k++) begin
            op_a[1]    = s_a[k];
            exp_sum[1] = s_sum[k];
            step(4'b0010, 1'b0, 4'b0010, (k < 4) ? k : 4, 0);
        end
        drain(4);

        // Hold with two ops in flight (ptr=2 here)
        op_a[0] = 16'h4000; op_b[0] = 16'h3C00; exp_sum[0] = 16'h4200;
        op_a[1] = 16'h4400; op_b[1] = 16'h4000; exp_sum[1] = 16'h4600;
        op_a[3] = 16'h4500; op_b[3] = 16'h3C00; exp_sum[3] = 16'h4600;
        step(4'b0011, 1'b0, 4'b0001, 0, 0);
        step(4'b0010, 1'b0, 4'b0010, 1, 0);
        step(4'b1000, 1'b1, 4'b0000, 2, 0);
        step(4'b1000, 1'b1, 4'b0000, 2, 0);
        step(4'b1000, 1'b1, 4'b0000, 2, 0);
        step(4'b1000, 1'b1, 4'b0000, 1, 0);
        step(4'b1000, 1'b1, 4'b0000, 0, 0);
        step(4'b1000, 1'b1, 4'b0000, 0, 0);
        step(4'b1000, 1'b0, 4'b1000, 0, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 0, 1);

        // Reset mid-flight: three ops discarded (ptr would be 3 without reset)
        sb_en = 1'b0;
        step(4'b0111, 1'b0, 4'b0001, 0, 0);
        step(4'b0110, 1'b0, 4'b0010, 1, 0);
        step(4'b0100, 1'b0, 4'b0100, 2, 0);
        rst_n     = 1'b0;
        req_valid = 4'b0111;
        @(negedge clk);
        chk("midrst req_ready", req_ready, 0);
        chk("midrst in_flight", in_flight, 0);
        chk("midrst rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        sb_en     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post-reset rsp_valid", rsp_valid, 0);
            chk("post-reset in_flight", in_flight, 0);
            @(posedge clk);
            #1;
        end
        op_a[0] = 16'h4700; op_b[0] = 16'h4700; exp_sum[0] = 16'h4B00;
        step(4'b1111, 1'b0, 4'b0001, 0, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 1, 0);
        step(4'b0000, 1'b0, 4'b0000, 0, 1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
